// File: rtl/joint_ramp_sched.sv
// joint_ramp_sched
// Moves each joint's step-frequency command towards a host-supplied target
// with bounded acceleration. One shared update datapath is time-multiplexed
// across the joints: each ramp tick starts a sweep that updates one joint
// per cycle. A command watchdog latches ERROR when the host goes silent.
// While ERROR is set, every joint ramps down to zero and its enable drops
// once it has stopped.
//
// Ports
//   sysclk          system clock
//   rst_n           asynchronous active-low reset
//   cmd_valid       command present
//   cmd_ready       command accepted when cmd_valid && cmd_ready (= !error)
//   cmd_joint       joint index of command (indices >= NUM_JOINTS are discarded)
//   cmd_target      signed target frequency
//   cmd_enable      joint enable carried with command
//   clr_error       single-cycle error clear request
//   joint_freq_cmd  signed freq cmd per joint, joint j at [32j+31:32j]
//   joint_enable    per-joint enable
//   error           latched watchdog error
//   busy            update sweep in progress
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the next ramp tick
// S_SWEEP | updating joint j_q this cycle; returns to idle after the last joint
module joint_ramp_sched #(
   parameter int NUM_JOINTS = 3,
   parameter int TICK_DIV   = 27000,
   parameter int ACCEL_STEP = 100,
   parameter int WDT_CYCLES = 13500000
) (
   input  logic                    sysclk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [2:0]              cmd_joint,
   input  logic [31:0]             cmd_target,
   input  logic                    cmd_enable,
   input  logic                    clr_error,
   output logic [32*NUM_JOINTS-1:0] joint_freq_cmd,
   output logic [NUM_JOINTS-1:0]   joint_enable,
   output logic                    error,
   output logic                    busy
);

   localparam int JIW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW  = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

   localparam logic signed [33:0] STEP    = 34'(ACCEL_STEP);
   localparam logic signed [33:0] SAT_MAX = 34'sd2147483647;
   localparam logic signed [33:0] SAT_MIN = -34'sd2147483648;

   typedef enum logic {
      S_IDLE,
      S_SWEEP
   } state_t;

   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic [WW-1:0]      wdt_cnt;
   logic               error_q;

   state_t             state_q;
   state_t             state_d;
   logic [JIW-1:0]     j_q;
   logic [JIW-1:0]     j_d;
   logic               upd;

   logic signed [31:0] freq_q   [NUM_JOINTS];
   logic signed [31:0] target_q [NUM_JOINTS];
   logic [NUM_JOINTS-1:0] en_q;

   logic signed [31:0] cur_freq;
   logic signed [31:0] cur_tgt;
   logic signed [31:0] freq_new;
   logic signed [33:0] diff;
   logic signed [33:0] diff_abs;
   logic signed [33:0] sum;

   logic               cmd_accept;
   logic               all_zero;
   logic               clr_ok;

   assign cmd_ready    = !error_q;
   assign cmd_accept   = cmd_valid && !error_q;
   assign error        = error_q;
   assign busy         = (state_q == S_SWEEP);
   assign joint_enable = en_q;
   assign tick         = (tick_cnt == TW'(TICK_DIV - 1));

   always_comb begin
      all_zero = 1'b1;
      for (int i = 0; i < NUM_JOINTS; i++) begin
         if (freq_q[i] != '0) all_zero = 1'b0;
      end
   end

   // Clearing is only honoured once every joint has actually stopped.
   assign clr_ok = clr_error && error_q && all_zero;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Error is raised on the same edge the counter reaches WDT_CYCLES-1; the
   // counter then freezes until the error is cleared.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt <= '0;
         error_q <= 1'b0;
      end else if (cmd_accept) begin
         wdt_cnt <= '0;
      end else if (clr_ok) begin
         wdt_cnt <= '0;
         error_q <= 1'b0;
      end else if (!error_q) begin
         wdt_cnt <= wdt_cnt + 1'b1;
         if (wdt_cnt == WW'(WDT_CYCLES - 2)) error_q <= 1'b1;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
      end
   end

   // Ticks arriving during a sweep are dropped.
   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      upd     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_SWEEP;
               j_d     = '0;
            end
         end
         S_SWEEP: begin
            upd = 1'b1;
            if (j_q == JIW'(NUM_JOINTS - 1)) begin
               state_d = S_IDLE;
               j_d     = '0;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            j_d     = '0;
         end
      endcase
   end

   // Shared ramp datapath for the joint in the current slot. Targets are read
   // from the registers, so a command landing in this slot takes effect on the
   // following tick.
   always_comb begin
      cur_freq = '0;
      cur_tgt  = '0;
      for (int i = 0; i < NUM_JOINTS; i++) begin
         if (j_q == JIW'(i)) begin
            cur_freq = freq_q[i];
            cur_tgt  = error_q ? 32'sd0 : target_q[i];
         end
      end
      // 34 bits so that the magnitude of the most negative difference fits.
      diff     = 34'(cur_tgt) - 34'(cur_freq);
      diff_abs = diff[33] ? -diff : diff;
      if (diff_abs <= STEP) begin
         sum = 34'(cur_tgt);
      end else if (!diff[33]) begin
         sum = 34'(cur_freq) + STEP;
      end else begin
         sum = 34'(cur_freq) - STEP;
      end
      if (sum > SAT_MAX) begin
         freq_new = 32'sh7FFF_FFFF;
      end else if (sum < SAT_MIN) begin
         freq_new = 32'sh8000_0000;
      end else begin
         freq_new = sum[31:0];
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_JOINTS; i++) begin
            freq_q[i]   <= '0;
            target_q[i] <= '0;
         end
         en_q <= '0;
      end else begin
         for (int i = 0; i < NUM_JOINTS; i++) begin
            if (cmd_accept && (cmd_joint == 3'(i))) begin
               target_q[i] <= cmd_target;
               en_q[i]     <= cmd_enable;
            end else if (error_q) begin
               // Enable falls the cycle after the joint is seen stopped.
               target_q[i] <= '0;
               if (freq_q[i] == '0) en_q[i] <= 1'b0;
            end
            if (upd && (j_q == JIW'(i))) freq_q[i] <= freq_new;
         end
      end
   end

   always_comb begin
      joint_freq_cmd = '0;
      for (int i = 0; i < NUM_JOINTS; i++) begin
         joint_freq_cmd[32*i +: 32] = freq_q[i];
      end
   end

endmodule
